// File: rtl/sha1_reqmaster.sv
// SHA-1 register-bus initiator: writes a 512-bit block word by word,
// starts the core, then hands the digest to the user.
module sha1_reqmaster #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 32,
  parameter int DataBytes = DataWidth / 8,
  parameter bit ByteAlign = 1'b1,
  parameter logic [AddrWidth-1:0] BaseAddr = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [511:0]         block_i,
  input  logic                 block_valid_i,
  output logic                 block_ready_o,
  output logic [DataWidth-1:0] sha_m_reqdata_o,
  output logic [AddrWidth-1:0] sha_m_reqaddr_o,
  output logic                 sha_m_reqvalid_o,
  output logic                 sha_m_reqwrite_o,
  output logic [DataBytes-1:0] sha_m_reqstrobe_o,
  input  logic                 sha_m_reqready_i,
  output logic                 sha_m_rspready_o,
  input  logic                 sha_m_rspvalid_i,
  input  logic [DataWidth-1:0] sha_m_rspdata_i,
  input  logic                 sha_m_rsperror_i,
  output logic                 sha_process_o,
  input  logic [159:0]         sha_digest_i,
  input  logic                 sha_digestvalid_i,
  output logic                 sha_digestack_o,
  output logic [159:0]         digest_o,
  output logic                 digest_valid_o,
  input  logic                 digest_ready_i,
  output logic                 error_o
);

  localparam int NumRegs  = 512 / DataWidth;
  localparam int CntW     = $clog2(NumRegs);
  localparam int AddrStep = ByteAlign ? DataWidth / 8 : DataWidth / 32;

  localparam logic [CntW-1:0]      LastCnt = CntW'(NumRegs - 1);
  localparam logic [AddrWidth-1:0] StepA   = AddrWidth'(AddrStep);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] PROCESS = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0] state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NumRegs-1:0][DataWidth-1:0] block_q;
  logic [159:0] digest_q;

  logic in_idle, in_write, in_wait, in_done;
  logic take, bus_err, beat_ok;
  logic unused_rspdata;

  assign in_idle  = state_q == IDLE;
  assign in_write = state_q == WRITE;
  assign in_wait  = state_q == WAIT;
  assign in_done  = state_q == DONE;

  assign take    = in_idle & block_valid_i;
  assign bus_err = in_write & sha_m_rsperror_i;
  // A beat needs both the request accepted and its response in one cycle
  assign beat_ok = in_write & sha_m_reqready_i
                 & sha_m_rspvalid_i & ~sha_m_rsperror_i;

  assign unused_rspdata = ^sha_m_rspdata_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (block_valid_i) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      (state_q == WRITE): begin
        if (bus_err) begin
          state_d = IDLE;
        end else if (beat_ok) begin
          if (cnt_q == LastCnt) state_d = PROCESS;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      (state_q == PROCESS): state_d = WAIT;
      (state_q == WAIT): begin
        if (sha_digestvalid_i) state_d = DONE;
      end
      (state_q == DONE): begin
        if (digest_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      block_q  <= '0;
      digest_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) block_q <= block_i;
      else if (bus_err) block_q <= '0;
      if (in_wait && sha_digestvalid_i) digest_q <= sha_digest_i;
    end
  end

  assign block_ready_o     = in_idle;
  assign sha_m_reqvalid_o  = in_write;
  assign sha_m_reqwrite_o  = in_write;
  assign sha_m_rspready_o  = in_write;
  assign sha_m_reqstrobe_o = {DataBytes{in_write}};
  assign sha_m_reqaddr_o   = in_write
                           ? BaseAddr + AddrWidth'(cnt_q) * StepA
                           : '0;
  assign sha_m_reqdata_o   = in_write ? block_q[cnt_q] : '0;
  assign sha_process_o     = state_q == PROCESS;
  assign sha_digestack_o   = in_done & digest_ready_i;
  assign digest_o          = digest_q;
  assign digest_valid_o    = in_done;
  assign error_o           = bus_err;

endmodule

// File: tb/tb_sha1_reqmaster.sv
// Bench for sha1_reqmaster: cycle model plus directed and random traffic,
// and a 32-bit word-addressed instance.
module tb_sha1_reqmaster;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [511:0] blk = '0;
  logic bvalid = 0, bready;
  logic [63:0] rq_data;
  logic [31:0] rq_addr;
  logic rqv, rqw, rspready;
  logic [7:0] strb;
  logic rqready = 0, rvalid = 0, rerr = 0;
  logic [63:0] rdata = '0;
  logic proc, ack, dv, err;
  logic [159:0] dig_in = '0, dig;
  logic dvalid_in = 0, dready = 0;

  sha1_reqmaster dut (
    .clk_i(clk), .rst_ni(rst_n),
    .block_i(blk), .block_valid_i(bvalid), .block_ready_o(bready),
    .sha_m_reqdata_o(rq_data), .sha_m_reqaddr_o(rq_addr),
    .sha_m_reqvalid_o(rqv), .sha_m_reqwrite_o(rqw),
    .sha_m_reqstrobe_o(strb), .sha_m_reqready_i(rqready),
    .sha_m_rspready_o(rspready), .sha_m_rspvalid_i(rvalid),
    .sha_m_rspdata_i(rdata), .sha_m_rsperror_i(rerr),
    .sha_process_o(proc), .sha_digest_i(dig_in),
    .sha_digestvalid_i(dvalid_in), .sha_digestack_o(ack),
    .digest_o(dig), .digest_valid_o(dv), .digest_ready_i(dready),
    .error_o(err)
  );

  logic [511:0] b_blk = '0;
  logic b_bvalid = 0, b_bready;
  logic [31:0] b_data, b_addr;
  logic b_rqv, b_rqw, b_rspready;
  logic [3:0] b_strb;
  logic b_rqready = 0, b_rvalid = 0, b_rerr = 0;
  logic [31:0] b_rdata = '0;
  logic b_proc, b_ack, b_dv, b_err;
  logic [159:0] b_dig_in = '0, b_dig;
  logic b_dvalid_in = 0, b_dready = 0;

  sha1_reqmaster #(
    .DataWidth(32), .ByteAlign(1'b0), .BaseAddr(32'h100)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .block_i(b_blk), .block_valid_i(b_bvalid), .block_ready_o(b_bready),
    .sha_m_reqdata_o(b_data), .sha_m_reqaddr_o(b_addr),
    .sha_m_reqvalid_o(b_rqv), .sha_m_reqwrite_o(b_rqw),
    .sha_m_reqstrobe_o(b_strb), .sha_m_reqready_i(b_rqready),
    .sha_m_rspready_o(b_rspready), .sha_m_rspvalid_i(b_rvalid),
    .sha_m_rspdata_i(b_rdata), .sha_m_rsperror_i(b_rerr),
    .sha_process_o(b_proc), .sha_digest_i(b_dig_in),
    .sha_digestvalid_i(b_dvalid_in), .sha_digestack_o(b_ack),
    .digest_o(b_dig), .digest_valid_o(b_dv), .digest_ready_i(b_dready),
    .error_o(b_err)
  );

  int n_pass = 0, n_tot = 0;
  int n_proc = 0, n_ack = 0;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pat();
    logic [511:0] p;
    for (int r = 0; r < 8; r++)
      p[r*64 +: 64] = 64'h0101010101010101 * 64'(r + 1);
    return p;
  endfunction

  function automatic logic [511:0] rnd_blk();
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic logic [159:0] rnd_dig();
    logic [159:0] d;
    for (int i = 0; i < 5; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Transaction-level model: phase 0 idle, 1 writing, 2 start pulse,
  // 3 waiting for core, 4 digest offered
  int ph = 0, beat = 0;
  logic [511:0] mblk = '0;
  logic [159:0] mdig = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; beat = 0; mblk = '0; mdig = '0;
    end else begin
      case (ph)
        0: if (bvalid) begin mblk = blk; beat = 0; ph = 1; end
        1: if (rerr) ph = 0;
           else if (rqready && rvalid) begin
             if (beat == 7) ph = 2; else beat++;
           end
        2: ph = 3;
        3: if (dvalid_in) begin mdig = dig_in; ph = 4; end
        4: if (dready) ph = 0;
        default: ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("block_ready", bready, ph == 0);
    chk("reqvalid", rqv, ph == 1);
    chk("reqwrite", rqw, ph == 1);
    chk("rspready", rspready, ph == 1);
    chk("reqaddr", rq_addr, ph == 1 ? beat * 8 : 0);
    chk("reqdata", rq_data, ph == 1 ? mblk[beat*64 +: 64] : 64'h0);
    chk("strobe", strb, ph == 1 ? 8'hFF : 8'h00);
    chk("error", err, ph == 1 && rerr);
    chk("process", proc, ph == 2);
    chk("digestack", ack, ph == 4 && dready);
    chk("digest_valid", dv, ph == 4);
    chk("digest", dig, mdig);
    if (proc) n_proc++;
    if (ack) n_ack++;
  end

  task automatic give_digest(input logic [159:0] d);
    dvalid_in = 1; dig_in = d;
    step;
    dvalid_in = 0; dig_in = '0;
  endtask

  localparam logic [159:0] AbcDig =
    160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;

  initial begin
    int stall_cyc, p0, a0;
    logic [511:0] bb;
    step; step;
    rst_n = 1;
    @(negedge clk);
    chk("rst block_ready", bready, 1);
    chk("rst reqvalid", rqv, 0);
    chk("rst digest", dig, 0);

    // Always-ready responder, 8 beats then one start pulse
    step;
    blk = pat(); bvalid = 1; rqready = 1; rvalid = 1; rerr = 0;
    @(negedge clk);
    chk("t1 ready", bready, 1);
    step;
    bvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1 addr", rq_addr, i * 8);
      chk("t1 data", rq_data, 64'h0101010101010101 * 64'(i + 1));
      chk("t1 strobe", strb, 8'hFF);
      step;
    end
    @(negedge clk);
    chk("t1 process", proc, 1);
    step;
    @(negedge clk);
    chk("t1 process once", proc, 0);
    step;
    give_digest(AbcDig);
    @(negedge clk);
    chk("t4 digest", dig, AbcDig);
    chk("t4 valid", dv, 1);
    for (int i = 0; i < 5; i++) begin
      step;
      @(negedge clk);
      chk("t4 hold valid", dv, 1);
      chk("t4 no ack", ack, 0);
    end
    step;
    dready = 1;
    @(negedge clk);
    chk("t4 ack", ack, 1);
    step;
    dready = 0;
    @(negedge clk);
    chk("t4 idle", bready, 1);
    chk("t4 ack once", ack, 0);

    // Responder stalls three cycles on beat 2
    step;
    p0 = n_proc;
    blk = pat(); bvalid = 1;
    step;
    bvalid = 0;
    beat = beat;
    stall_cyc = 0;
    begin
      int bt, st;
      bt = 0; st = 0;
      for (int c = 0; c < 20 && bt < 8; c++) begin
        rqready = !(bt == 2 && st < 3);
        if (!rqready) st++;
        @(negedge clk);
        if (bt == 2) begin
          stall_cyc++;
          chk("t2 addr", rq_addr, 32'h10);
          chk("t2 data", rq_data, 64'h0303030303030303);
        end
        if (rqready) bt++;
        step;
      end
      chk("t2 beats", bt, 8);
    end
    rqready = 1;
    chk("t2 stall cycles", stall_cyc, 4);
    @(negedge clk);
    chk("t2 process", proc, 1);
    step;
    chk("t2 one process", n_proc - p0, 1);
    give_digest(rnd_dig());
    dready = 1;
    step;
    dready = 0;

    // Bus error on beat 5, even with a completing response
    p0 = n_proc;
    blk = rnd_blk(); bvalid = 1;
    step;
    bvalid = 0;
    repeat (5) step;
    rerr = 1;
    @(negedge clk);
    chk("t3 error", err, 1);
    chk("t3 addr", rq_addr, 32'h28);
    step;
    rerr = 0;
    @(negedge clk);
    chk("t3 idle", bready, 1);
    chk("t3 error pulse", err, 0);
    step;
    chk("t3 no process", n_proc, p0);
    blk = rnd_blk(); bvalid = 1;
    step;
    bvalid = 0;
    @(negedge clk);
    chk("t3 restart addr", rq_addr, 0);
    repeat (8) step;
    @(negedge clk);
    chk("t3 process", proc, 1);
    step;
    give_digest(rnd_dig());
    dready = 1;
    step;
    dready = 0;

    // Reset during beat 4
    p0 = n_proc; a0 = n_ack;
    blk = rnd_blk(); bvalid = 1;
    step;
    bvalid = 0;
    repeat (4) step;
    #1 rst_n = 0;
    #1;
    chk("t5 rst ready", bready, 1);
    chk("t5 rst reqvalid", rqv, 0);
    chk("t5 rst addr", rq_addr, 0);
    chk("t5 rst digest_valid", dv, 0);
    step;
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      dvalid_in = (i % 3 == 0); dig_in = rnd_dig(); dready = 1;
      step;
    end
    dvalid_in = 0; dready = 0;
    chk("t5 no process", n_proc, p0);
    chk("t5 no ack", n_ack, a0);

    // Random traffic against the model
    p0 = n_proc;
    for (int c = 0; c < 3000; c++) begin
      bvalid = ($urandom % 3) == 0;
      blk = rnd_blk();
      rqready = ($urandom % 4) != 0;
      rvalid = ($urandom % 4) != 0;
      rerr = ($urandom % 40) == 0;
      rdata = {$urandom, $urandom};
      dvalid_in = ($urandom % 5) == 0;
      dig_in = rnd_dig();
      dready = ($urandom % 3) == 0;
      step;
    end
    bvalid = 0; rerr = 0; dvalid_in = 0; dready = 0;
    chk("rand made progress", n_proc > p0 + 10, 1);

    // 32-bit word-addressed instance
    bb = rnd_blk();
    b_blk = bb; b_bvalid = 1; b_rqready = 1; b_rvalid = 1;
    @(negedge clk);
    chk("w32 ready", b_bready, 1);
    step;
    b_bvalid = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("w32 addr", b_addr, 32'h100 + i);
      chk("w32 strobe", b_strb, 4'hF);
      chk("w32 data", b_data, bb[i*32 +: 32]);
      step;
    end
    @(negedge clk);
    chk("w32 process", b_proc, 1);
    step;
    b_dvalid_in = 1; b_dig_in = AbcDig;
    step;
    b_dvalid_in = 0;
    @(negedge clk);
    chk("w32 digest", b_dig, AbcDig);
    chk("w32 valid", b_dv, 1);
    step;
    b_dready = 1;
    #1;
    chk("w32 ack", b_ack, 1);
    step;
    b_dready = 0;
    @(negedge clk);
    chk("w32 idle", b_bready, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
